image_ram_arbiter: RTL and testbench
====================================

// Module: image_ram_arbiter
// PURPOSE
//  Shares the single-port 4096x32 image RAM between the host bus and the edge-detection
//  coprocessor's row-fetch (read) and result-writeback (write) ports. Issues at most one
//  RAM access per cycle and returns read data tagged to the requester that owns it.
//  Host has priority, bounded by a starvation limit; the two coprocessor ports share
//  round-robin.
// PARAMETERS
//  ADDR_W       12  RAM address width
//  DATA_W       32  RAM data width
//  RD_LATENCY    2  cycles from ram_addr driven to ram_q valid (1..4)
//  STARVE_LIMIT  4  consecutive host grants allowed while a coprocessor port waits (1..15)
// PORTS
//  clk_50M      in   1       system clock
//  reset        in   1       reset, synchronous, active-low
//  host_req     in   1       host access request; held until host_gnt
//  host_we      in   1       1=write, 0=read
//  host_addr    in   ADDR_W  host address
//  host_wdata   in   DATA_W  host write data
//  host_gnt     out  1       1-cycle pulse: host access accepted
//  host_rvalid  out  1       1-cycle pulse: host_rdata valid
//  host_rdata   out  DATA_W  host read data
//  cp_rd_req    in   1       coprocessor row-fetch request; held until cp_rd_gnt
//  cp_rd_addr   in   ADDR_W  fetch address
//  cp_rd_gnt    out  1       1-cycle pulse: fetch accepted
//  cp_rd_valid  out  1       1-cycle pulse: cp_rd_data valid
//  cp_rd_data   out  DATA_W  fetched word
//  cp_wr_req    in   1       coprocessor writeback request; held until cp_wr_gnt
//  cp_wr_addr   in   ADDR_W  writeback address
//  cp_wr_data   in   DATA_W  writeback data
//  cp_wr_gnt    out  1       1-cycle pulse: writeback accepted
//  ram_addr     out  ADDR_W  RAM address (registered)
//  ram_wren     out  1       RAM write enable (registered)
//  ram_data     out  DATA_W  RAM write data (registered)
//  ram_q        in   DATA_W  RAM read data
//  busy         out  1       any request pending or read in flight
// BEHAVIOUR
//  - Reset (reset==0 at posedge): all gnt/valid/ram_wren=0, ram_addr/ram_data/rdata=0,
//    starve count=0, RR pointer=RD, in-flight read pipeline cleared (pending data dropped).
//  - Cycle N: combinational arbitration on requests; winner's gnt=1 in cycle N.
//    Cycle N+1: ram_addr/ram_wren/ram_data hold winner's access (ram_wren=0 when idle).
//    Read: data on ram_q at N+1+RD_LATENCY; rvalid/rdata registered => valid at N+2+RD_LATENCY.
//  - Requester must keep req/addr/data stable until gnt; may drop req the cycle after gnt,
//    or keep it high for back-to-back accesses (one grant per cycle max, one per port).
//  - Priority: host wins if host_req and (no cp req pending or starve_cnt<STARVE_LIMIT).
//    starve_cnt: +1 on host grant while any cp req pending; cleared on any cp grant
//    or when no cp req pending. At limit, the cp side wins the cycle.
//  - CP round-robin: rd and wr both pending -> grant port at RR pointer, pointer toggles
//    to the other port; only one pending -> it wins, pointer set to the other port.
//  - Read tagging: shift register depth RD_LATENCY+1 of {valid,owner}; owner in {HOST,CP}.
//    Reads return in issue order; writes insert bubbles.
//  - Read-after-write same address: strictly issue order; the later read sees new data.
//  - Host write: no response other than host_gnt.
//  - busy = host_req|cp_rd_req|cp_wr_req|any pipeline valid.
//  - Reset mid-access: in-flight reads never produce rvalid; the access in the ram_* register
//    is cancelled (ram_wren forced 0 the cycle after reset is sampled).
// TESTING
//  1 Host read 0x010 alone, RD_LATENCY=2: host_gnt at N, ram_addr=0x010 at N+1,
//    host_rvalid at N+4 with RAM content.
//  2 cp_rd_req+cp_wr_req held continuously: grants alternate RD,WR,RD,WR starting with RD.
//  3 host_req and cp_rd_req held, STARVE_LIMIT=4: grants H,H,H,H,CP,H,H,H,H,CP...
//  4 cp write 0x0AB to 0x100 then cp read 0x100 back-to-back: cp_rd_data=0x0AB.
//  5 Interleaved host read A, cp read B, host read C: each rvalid goes to the right port,
//    in order, no cross-delivery.
//  6 Assert reset 1 cycle after a host read grant: no host_rvalid, ram_wren=0, busy=0 after.

Source files
------------

// File: rtl/image_ram_arbiter_if.sv
// Bus bundle between the host, the edge-detection coprocessor ports,
// the image RAM and the arbiter that shares that RAM among them.
interface image_ram_arbiter_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
);
  // host bus
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;
  // coprocessor row-fetch port
  logic              cp_rd_req;
  logic [ADDR_W-1:0] cp_rd_addr;
  logic              cp_rd_gnt;
  logic              cp_rd_valid;
  logic [DATA_W-1:0] cp_rd_data;
  // coprocessor result-writeback port
  logic              cp_wr_req;
  logic [ADDR_W-1:0] cp_wr_addr;
  logic [DATA_W-1:0] cp_wr_data;
  logic              cp_wr_gnt;
  // RAM side
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_data;
  logic [DATA_W-1:0] ram_q;
  // status
  logic              busy;

  // arbiter view
  modport slave (
    input  host_req, host_we, host_addr, host_wdata,
    input  cp_rd_req, cp_rd_addr,
    input  cp_wr_req, cp_wr_addr, cp_wr_data,
    input  ram_q,
    output host_gnt, host_rvalid, host_rdata,
    output cp_rd_gnt, cp_rd_valid, cp_rd_data,
    output cp_wr_gnt,
    output ram_addr, ram_wren, ram_data,
    output busy
  );

  // requester / RAM view
  modport master (
    output host_req, host_we, host_addr, host_wdata,
    output cp_rd_req, cp_rd_addr,
    output cp_wr_req, cp_wr_addr, cp_wr_data,
    output ram_q,
    input  host_gnt, host_rvalid, host_rdata,
    input  cp_rd_gnt, cp_rd_valid, cp_rd_data,
    input  cp_wr_gnt,
    input  ram_addr, ram_wren, ram_data,
    input  busy
  );
endinterface

// File: rtl/image_ram_arbiter.sv
// Shares the single-port image RAM between the host bus and the coprocessor
// row-fetch / writeback ports. One RAM access per cycle; read data returns
// in issue order, tagged to the requester that issued it. Host has priority
// bounded by a starvation limit; the two coprocessor ports alternate.
module image_ram_arbiter #(
  parameter int unsigned ADDR_W       = 12,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned RD_LATENCY   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                clk_50M,
  input logic                reset,
  image_ram_arbiter_if.slave bus
);

  typedef enum logic { OWN_HOST = 1'b0, OWN_CP = 1'b1 } owner_e;
  typedef enum logic { RR_RD = 1'b0, RR_WR = 1'b1 } rr_e;
  typedef struct packed {
    logic   valid;
    owner_e owner;
  } tag_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [3:0]         starve_cnt;
  rr_e                rr_ptr;
  tag_t [RD_LATENCY:0] rd_pipe;
  tag_t               issue_tag;
  logic               cp_pend;
  logic               host_win;
  logic               cp_win;
  logic               rd_win;
  logic               wr_win;
  logic               pipe_busy;

  logic [ADDR_W-1:0]  ram_addr_q;
  logic               ram_wren_q;
  logic [DATA_W-1:0]  ram_data_q;
  logic               host_rvalid_q;
  logic [DATA_W-1:0]  host_rdata_q;
  logic               cp_rd_valid_q;
  logic [DATA_W-1:0]  cp_rd_data_q;

  // Same-cycle arbitration; no grant is issued while reset is asserted.
  always_comb begin
    cp_pend  = bus.cp_rd_req | bus.cp_wr_req;
    host_win = reset & bus.host_req & (~cp_pend | (starve_cnt < STARVE_MAX));
    cp_win   = reset & cp_pend & ~host_win;
    rd_win   = cp_win & bus.cp_rd_req & (~bus.cp_wr_req | (rr_ptr == RR_RD));
    wr_win   = cp_win & bus.cp_wr_req & ~rd_win;
  end

  // Starvation counter and coprocessor round-robin pointer.
  // Pointing at the other port after any cp grant covers both the
  // contended toggle and the single-requester case.
  always_ff @(posedge clk_50M) begin
    if (!reset) begin
      starve_cnt <= '0;
      rr_ptr     <= RR_RD;
    end else begin
      if (cp_win || !cp_pend)
        starve_cnt <= '0;
      else if (host_win && (starve_cnt < STARVE_MAX))
        starve_cnt <= starve_cnt + 4'd1;
      if (rd_win)
        rr_ptr <= RR_WR;
      else if (wr_win)
        rr_ptr <= RR_RD;
    end
  end

  // Register the winning access onto the RAM port; idle cycles never write.
  always_ff @(posedge clk_50M) begin
    if (!reset) begin
      ram_addr_q <= '0;
      ram_wren_q <= 1'b0;
      ram_data_q <= '0;
    end else if (host_win) begin
      ram_addr_q <= bus.host_addr;
      ram_wren_q <= bus.host_we;
      ram_data_q <= bus.host_wdata;
    end else if (rd_win) begin
      ram_addr_q <= bus.cp_rd_addr;
      ram_wren_q <= 1'b0;
    end else if (wr_win) begin
      ram_addr_q <= bus.cp_wr_addr;
      ram_wren_q <= 1'b1;
      ram_data_q <= bus.cp_wr_data;
    end else begin
      ram_wren_q <= 1'b0;
    end
  end

  // Tag describing the read (if any) issued this cycle.
  always_comb begin
    issue_tag.valid = (host_win & ~bus.host_we) | rd_win;
    issue_tag.owner = rd_win ? OWN_CP : OWN_HOST;
  end

  // Read-owner shift register; stage RD_LATENCY lines up with ram_q.
  always_ff @(posedge clk_50M) begin
    if (!reset) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe[0] <= issue_tag;
      for (int unsigned i = 1; i <= RD_LATENCY; i++)
        rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  // Any read still travelling through the owner pipeline.
  always_comb begin
    pipe_busy = 1'b0;
    for (int unsigned i = 0; i <= RD_LATENCY; i++)
      pipe_busy = pipe_busy | rd_pipe[i].valid;
  end

  // Steer returning RAM data to its owner as registered responses.
  always_ff @(posedge clk_50M) begin
    if (!reset) begin
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
      cp_rd_valid_q <= 1'b0;
      cp_rd_data_q  <= '0;
    end else begin
      host_rvalid_q <= rd_pipe[RD_LATENCY].valid && (rd_pipe[RD_LATENCY].owner == OWN_HOST);
      cp_rd_valid_q <= rd_pipe[RD_LATENCY].valid && (rd_pipe[RD_LATENCY].owner == OWN_CP);
      if (rd_pipe[RD_LATENCY].valid && (rd_pipe[RD_LATENCY].owner == OWN_HOST))
        host_rdata_q <= bus.ram_q;
      if (rd_pipe[RD_LATENCY].valid && (rd_pipe[RD_LATENCY].owner == OWN_CP))
        cp_rd_data_q <= bus.ram_q;
    end
  end

  assign bus.host_gnt    = host_win;
  assign bus.cp_rd_gnt   = rd_win;
  assign bus.cp_wr_gnt   = wr_win;
  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_wren    = ram_wren_q;
  assign bus.ram_data    = ram_data_q;
  assign bus.host_rvalid = host_rvalid_q;
  assign bus.host_rdata  = host_rdata_q;
  assign bus.cp_rd_valid = cp_rd_valid_q;
  assign bus.cp_rd_data  = cp_rd_data_q;
  assign bus.busy        = bus.host_req | cp_pend | pipe_busy;

endmodule

// File: tb/tb_image_ram_arbiter.sv
// Self-checking bench for image_ram_arbiter: reset state, table-driven
// arbitration vectors, hand-written multi-cycle sequences and a randomized
// run against a request-level reference model with a golden memory.
module tb_image_ram_arbiter;

  localparam int unsigned ADDR_W       = 12;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned RD_LATENCY   = 2;
  localparam int unsigned STARVE_LIMIT = 4;
  localparam int unsigned RESP_DLY     = RD_LATENCY + 2;  // grant cycle -> rvalid cycle
  localparam int unsigned RAND_CYCLES  = 600;

  logic clk_50M = 1'b0;
  logic reset   = 1'b0;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  image_ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  image_ram_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .RD_LATENCY(RD_LATENCY),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk_50M(clk_50M),
    .reset(reset),
    .bus(bus)
  );

  always #10 clk_50M = ~clk_50M;

  function automatic logic [31:0] init_val(input logic [11:0] a);
    return 32'hC0DE_0000 ^ {20'h0, a} ^ ({20'h0, a} << 20);
  endfunction

  // RAM model: synchronous, RD_LATENCY cycles from ram_addr to ram_q.
  logic [DATA_W-1:0] mem [4096];
  logic [DATA_W-1:0] rdq [RD_LATENCY];
  bit mem_ready = 1'b0;
  always @(posedge clk_50M) begin
    if (!mem_ready) begin
      for (int i = 0; i < 4096; i++) mem[i] <= init_val(12'(i));
      mem_ready <= 1'b1;
    end else if (bus.ram_wren) begin
      mem[bus.ram_addr] <= bus.ram_data;
    end
    rdq[0] <= mem[bus.ram_addr];
    for (int i = 1; i < RD_LATENCY; i++) rdq[i] <= rdq[i-1];
  end
  assign bus.ram_q = rdq[RD_LATENCY-1];

  logic [DATA_W-1:0] gold [4096];

  typedef struct {
    logic       h;
    logic       hwe;
    logic       rd;
    logic       wr;
    logic [2:0] exp;  // {host, rd, wr} grants
  } vec_t;

  typedef struct {
    int unsigned due;
    bit          host;
    logic [31:0] data;
  } resp_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] gnts();
    return {bus.host_gnt, bus.cp_rd_gnt, bus.cp_wr_gnt};
  endfunction

  task automatic drive(input logic h, input logic hwe, input logic [11:0] ha, input logic [31:0] hd,
                       input logic r, input logic [11:0] ra,
                       input logic w, input logic [11:0] wa, input logic [31:0] wd);
    bus.host_req   = h;
    bus.host_we    = hwe;
    bus.host_addr  = ha;
    bus.host_wdata = hd;
    bus.cp_rd_req  = r;
    bus.cp_rd_addr = ra;
    bus.cp_wr_req  = w;
    bus.cp_wr_addr = wa;
    bus.cp_wr_data = wd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic tick();
    @(posedge clk_50M);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle();
    repeat (2) tick();
    reset = 1'b1;
  endtask

  vec_t vecs[17];

  initial begin
    resp_t       rq[$];
    bit          ph, prd, pwr, hwe, last_wr, cp_any, exp_hv, exp_cv, exp_busy;
    logic [11:0] ha, ra, wa;
    logic [31:0] hd, wd;
    int unsigned streak, win;
    logic [2:0]  exp_g;

    for (int i = 0; i < 4096; i++) gold[i] = init_val(12'(i));

    // ---------------- reset state (requests held high during reset) ----------------
    idle();
    repeat (3) tick();
    drive(1'b1, 1'b0, 12'h001, '0, 1'b1, 12'h002, 1'b1, 12'h003, 32'h1);
    #9;
    chk("reset_gnts", gnts(), 3'b000);
    chk("reset_ram_wren", bus.ram_wren, 1'b0);
    chk("reset_ram_addr", bus.ram_addr, 12'h000);
    chk("reset_ram_data", bus.ram_data, 32'h0);
    chk("reset_host_rvalid", bus.host_rvalid, 1'b0);
    chk("reset_cp_rd_valid", bus.cp_rd_valid, 1'b0);
    chk("reset_host_rdata", bus.host_rdata, 32'h0);
    chk("reset_cp_rd_data", bus.cp_rd_data, 32'h0);
    tick();
    idle();
    tick();
    reset = 1'b1;
    #9;
    chk("reset_busy", bus.busy, 1'b0);
    tick();

    // ---------------- table-driven arbitration from fresh reset ----------------
    do_reset();
    vecs[0]  = '{h:0, hwe:0, rd:0, wr:0, exp:3'b000};
    vecs[1]  = '{h:1, hwe:1, rd:0, wr:0, exp:3'b100};
    vecs[2]  = '{h:0, hwe:0, rd:1, wr:0, exp:3'b010};
    vecs[3]  = '{h:0, hwe:0, rd:0, wr:1, exp:3'b001};
    vecs[4]  = '{h:0, hwe:0, rd:1, wr:1, exp:3'b010};
    vecs[5]  = '{h:0, hwe:0, rd:1, wr:1, exp:3'b001};
    vecs[6]  = '{h:0, hwe:0, rd:1, wr:1, exp:3'b010};
    vecs[7]  = '{h:1, hwe:0, rd:0, wr:1, exp:3'b100};
    vecs[8]  = '{h:1, hwe:1, rd:0, wr:1, exp:3'b100};
    vecs[9]  = '{h:1, hwe:0, rd:1, wr:1, exp:3'b100};
    vecs[10] = '{h:1, hwe:1, rd:1, wr:1, exp:3'b100};
    vecs[11] = '{h:1, hwe:0, rd:1, wr:1, exp:3'b001};
    vecs[12] = '{h:1, hwe:1, rd:1, wr:0, exp:3'b100};
    vecs[13] = '{h:0, hwe:0, rd:1, wr:0, exp:3'b010};
    vecs[14] = '{h:1, hwe:0, rd:0, wr:0, exp:3'b100};
    vecs[15] = '{h:1, hwe:1, rd:0, wr:1, exp:3'b100};
    vecs[16] = '{h:0, hwe:0, rd:0, wr:1, exp:3'b001};
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].h, vecs[i].hwe, 12'h300, 32'h1111_0000, vecs[i].rd, 12'h301,
            vecs[i].wr, 12'h302, 32'h2222_0000);
      #9;
      chk($sformatf("vec%0d_gnts", i), gnts(), vecs[i].exp);
      tick();
    end
    idle();
    repeat (6) tick();

    // ---------------- host read 0x010 alone: latency ----------------
    drive(1'b1, 1'b0, 12'h010, '0, 1'b0, '0, 1'b0, '0, '0);
    #9;
    chk("t1_host_gnt", bus.host_gnt, 1'b1);
    tick();
    idle();
    chk("t1_ram_addr", bus.ram_addr, 12'h010);
    chk("t1_ram_wren", bus.ram_wren, 1'b0);
    for (int unsigned k = 1; k <= RESP_DLY + 1; k++) begin
      chk($sformatf("t1_rvalid_c%0d", k), bus.host_rvalid, (k == RESP_DLY));
      if (k == RESP_DLY) chk("t1_rdata", bus.host_rdata, gold[12'h010]);
      tick();
    end

    // ---------------- rd+wr held: RD,WR,RD,WR ----------------
    do_reset();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 12'h040, 1'b1, 12'h3F0, 32'h5);
    for (int k = 0; k < 6; k++) begin
      #9;
      chk($sformatf("t2_gnts_%0d", k), gnts(), (k % 2 == 0) ? 3'b010 : 3'b001);
      tick();
    end
    idle();

    // ---------------- host+rd held: H x4 then CP ----------------
    do_reset();
    drive(1'b1, 1'b1, 12'h3E0, 32'h9, 1'b1, 12'h041, 1'b0, '0, '0);
    for (int k = 0; k < 10; k++) begin
      #9;
      chk($sformatf("t3_gnts_%0d", k), gnts(), (k % 5 == 4) ? 3'b010 : 3'b100);
      tick();
    end
    idle();
    repeat (6) tick();

    // ---------------- cp write then cp read same address ----------------
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1, 12'h100, 32'h0000_00AB);
    #9;
    chk("t4_wr_gnt", gnts(), 3'b001);
    gold[12'h100] = 32'h0000_00AB;
    tick();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 12'h100, 1'b0, '0, '0);
    #9;
    chk("t4_rd_gnt", gnts(), 3'b010);
    tick();
    idle();
    for (int unsigned k = 1; k <= RESP_DLY + 1; k++) begin
      chk($sformatf("t4_valid_c%0d", k), bus.cp_rd_valid, (k == RESP_DLY));
      if (k == RESP_DLY) chk("t4_data", bus.cp_rd_data, 32'h0000_00AB);
      tick();
    end
    repeat (3) tick();

    // ---------------- interleaved host A, cp B, host C ----------------
    drive(1'b1, 1'b0, 12'h020, '0, 1'b0, '0, 1'b0, '0, '0);
    #9;
    chk("t5_gnt_a", gnts(), 3'b100);
    tick();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 12'h030, 1'b0, '0, '0);
    #9;
    chk("t5_gnt_b", gnts(), 3'b010);
    tick();
    drive(1'b1, 1'b0, 12'h040, '0, 1'b0, '0, 1'b0, '0, '0);
    #9;
    chk("t5_gnt_c", gnts(), 3'b100);
    tick();
    idle();
    for (int unsigned c = 3; c <= RESP_DLY + 4; c++) begin
      chk($sformatf("t5_host_rvalid_c%0d", c), bus.host_rvalid,
          (c == RESP_DLY) || (c == RESP_DLY + 2));
      chk($sformatf("t5_cp_valid_c%0d", c), bus.cp_rd_valid, (c == RESP_DLY + 1));
      if (c == RESP_DLY)     chk("t5_data_a", bus.host_rdata, gold[12'h020]);
      if (c == RESP_DLY + 1) chk("t5_data_b", bus.cp_rd_data, gold[12'h030]);
      if (c == RESP_DLY + 2) chk("t5_data_c", bus.host_rdata, gold[12'h040]);
      tick();
    end

    // ---------------- reset one cycle after host read grant ----------------
    drive(1'b1, 1'b0, 12'h050, '0, 1'b0, '0, 1'b0, '0, '0);
    #9;
    chk("t6_gnt", gnts(), 3'b100);
    tick();
    idle();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("t6_rvalid_%0d", k), bus.host_rvalid, 1'b0);
      chk($sformatf("t6_wren_%0d", k), bus.ram_wren, 1'b0);
      chk($sformatf("t6_busy_%0d", k), bus.busy, 1'b0);
      tick();
    end

    // ---------------- reset one cycle after host write grant ----------------
    drive(1'b1, 1'b1, 12'h3C0, 32'hDEAD_BEEF, 1'b0, '0, 1'b0, '0, '0);
    #9;
    chk("t6b_gnt", gnts(), 3'b100);
    tick();
    idle();
    chk("t6b_wren_before", bus.ram_wren, 1'b1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("t6b_wren_after", bus.ram_wren, 1'b0);
    gold[12'h3C0] = 32'hDEAD_BEEF;

    // ---------------- randomized run vs reference model ----------------
    do_reset();
    ph = 0; prd = 0; pwr = 0; hwe = 0;
    ha = '0; ra = '0; wa = '0; hd = '0; wd = '0;
    streak = 0;
    last_wr = 1'b1;  // so the read port is first when both contend
    for (int unsigned c = 0; c < RAND_CYCLES + 14; c++) begin
      // registered responses visible in cycle c
      exp_hv = (rq.size() > 0) && (rq[0].due == c) && rq[0].host;
      exp_cv = (rq.size() > 0) && (rq[0].due == c) && !rq[0].host;
      chk("rand_host_rvalid", bus.host_rvalid, exp_hv);
      chk("rand_cp_rd_valid", bus.cp_rd_valid, exp_cv);
      if (exp_hv) chk("rand_host_rdata", bus.host_rdata, rq[0].data);
      if (exp_cv) chk("rand_cp_rd_data", bus.cp_rd_data, rq[0].data);
      if (exp_hv || exp_cv) void'(rq.pop_front());

      if (c < RAND_CYCLES) begin
        if (!ph && $urandom_range(0, 9) < 6) begin
          ph = 1; hwe = 1'($urandom_range(0, 1));
          ha = 12'h200 + 12'($urandom_range(0, 15)); hd = $urandom;
        end
        if (!prd && $urandom_range(0, 9) < 5) begin
          prd = 1; ra = 12'h200 + 12'($urandom_range(0, 15));
        end
        if (!pwr && $urandom_range(0, 9) < 4) begin
          pwr = 1; wa = 12'h200 + 12'($urandom_range(0, 15)); wd = $urandom;
        end
      end
      drive(ph, hwe, ha, hd, prd, ra, pwr, wa, wd);
      #9;

      exp_busy = ph | prd | pwr;
      foreach (rq[i])
        if ((c + 1 + RD_LATENCY >= rq[i].due) && (c + 1 <= rq[i].due)) exp_busy = 1'b1;
      chk("rand_busy", bus.busy, exp_busy);

      cp_any = prd | pwr;
      if (ph && (!cp_any || streak < STARVE_LIMIT)) win = 1;
      else if (prd && pwr) win = last_wr ? 2 : 3;
      else if (prd)        win = 2;
      else if (pwr)        win = 3;
      else                 win = 0;
      exp_g = (win == 1) ? 3'b100 : (win == 2) ? 3'b010 : (win == 3) ? 3'b001 : 3'b000;
      chk("rand_gnts", gnts(), exp_g);

      if (win == 2 || win == 3) begin
        streak  = 0;
        last_wr = (win == 3);
      end else if (!cp_any) begin
        streak = 0;
      end else if (win == 1) begin
        streak++;
      end

      case (win)
        1: begin
          if (hwe) gold[ha] = hd;
          else     rq.push_back('{due: c + RESP_DLY, host: 1'b1, data: gold[ha]});
          ph = 0;
        end
        2: begin
          rq.push_back('{due: c + RESP_DLY, host: 1'b0, data: gold[ra]});
          prd = 0;
        end
        3: begin
          gold[wa] = wd;
          pwr = 0;
        end
        default: ;
      endcase
      tick();
    end
    chk("rand_drained", rq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
